// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: 4-digit BCD stopwatch/countdown controller with prescaler and command FSM
// Ports: clk_i, reset_i (sync, active high); start_stop_i, clear_i, load_i, lap_i are 1-cycle
// command pulses; load_val_i is the BCD preset; mode_i picks the direction (0 up, 1 down) at start.
// q_o is the BCD value and lap_q_o the last lap capture. running_o and expired_o decode the state.
// wrap_o pulses on a 9999->0000 rollover, and err_o pulses one cycle after a rejected command.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_stop_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        mode_i,
  input  logic        lap_i,
  output logic [15:0] q_o,
  output logic [15:0] lap_q_o,
  output logic        running_o,
  output logic        expired_o,
  output logic        wrap_o,
  output logic        err_o
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;
  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   val_q, lap_q, up_d, dn_d, step_d;
  logic          dir_q, wrap_q, err_q, tick, ld_ok;
  logic [4:0]    c_up;
  logic [3:0]    c_dn, ld_dig_ok;
  // Decade cascade: a digit steps only when every lower digit sits at its wrap value.
  assign c_up[0] = 1'b1;
  assign c_dn[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    logic [3:0] d;
    assign d = val_q[4*i +: 4];
    assign up_d[4*i +: 4] = c_up[i] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign dn_d[4*i +: 4] = c_dn[i] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
    assign c_up[i+1] = c_up[i] && (d == 4'd9);
    assign ld_dig_ok[i] = load_val_i[4*i +: 4] <= 4'd9;
    if (i < 3) begin : g_c
      assign c_dn[i+1] = c_dn[i] && (d == 4'd0);
    end
  end
  assign ld_ok  = &ld_dig_ok;
  assign step_d = dir_q ? dn_d : up_d;
  assign tick   = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      val_q   <= '0;
      lap_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      // Lap captures the pre-edge value, independent of every other command.
      if (lap_i && (state_q == S_RUN || state_q == S_PAUSE)) lap_q <= val_q;
      if (clear_i) begin
        state_q <= S_IDLE;
        presc_q <= '0;
        val_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            presc_q <= '0;
            if (load_i) begin
              if (ld_ok) val_q <= load_val_i;
              else err_q <= 1'b1;
            end else if (start_stop_i) begin
              if (mode_i && val_q == 16'd0) err_q <= 1'b1;
              else begin
                state_q <= S_RUN;
                dir_q   <= mode_i;
              end
            end
          end
          S_RUN: begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            err_q   <= load_i;
            if (tick) begin
              val_q  <= step_d;
              wrap_q <= !dir_q && c_up[4];
            end
            // Reaching zero on a down step outranks a coincident pause request.
            if (tick && dir_q && step_d == 16'd0) state_q <= S_DONE;
            else if (start_stop_i && !load_i) state_q <= S_PAUSE;
          end
          S_PAUSE: begin
            if (load_i) err_q <= 1'b1;
            else if (start_stop_i) state_q <= S_RUN;
          end
          default: begin
            presc_q <= '0;
            if (load_i) begin
              if (ld_ok) begin
                val_q   <= load_val_i;
                state_q <= S_IDLE;
              end else err_q <= 1'b1;
            end else if (start_stop_i) begin
              val_q   <= '0;
              state_q <= S_IDLE;
            end
          end
        endcase
      end
    end
  end
  assign q_o       = val_q;
  assign lap_q_o   = lap_q;
  assign running_o = state_q == S_RUN;
  assign expired_o = state_q == S_DONE;
  assign wrap_o    = wrap_q;
  assign err_o     = err_q;
endmodule
